// File: rtl/instruction_cache_ctrl.sv
// instruction_cache_ctrl: direct-mapped read-only instruction cache with a single-line refill FSM
module instruction_cache_ctrl #(
    parameter int INDEX_BITS = 3,
    parameter int TAG_BITS   = 32 - INDEX_BITS - 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [31:0]  PC,
    input  logic         read,
    output logic [31:0]  Instruction,
    output logic         Insthit,
    output logic         busywait,
    output logic         mem_read,
    output logic [27:0]  mem_address,
    input  logic [127:0] mem_readdata,
    input  logic         mem_busywait
);
    localparam int LINES = 1 << INDEX_BITS;

    typedef enum logic [1:0] {IDLE, MEM_READ, UPDATE} state_t;

    state_t                state_q, state_d;
    logic [LINES-1:0]      valid_q, valid_d;
    logic [27:0]           miss_q, miss_d;
    logic [TAG_BITS-1:0]   tag_q  [LINES];
    logic [127:0]          data_q [LINES];
    logic [INDEX_BITS-1:0] idx;
    logic [INDEX_BITS-1:0] fill_idx;
    logic                  hit;
    logic                  fill;
    logic                  unused_pc;

    assign idx         = PC[3+INDEX_BITS:4];
    assign fill_idx    = miss_q[INDEX_BITS-1:0];
    assign hit         = (state_q == IDLE) && read && valid_q[idx] && (tag_q[idx] == PC[31:4+INDEX_BITS]);
    assign fill        = (state_q == MEM_READ) && !mem_busywait;
    assign mem_address = miss_q;
    assign unused_pc   = ^PC[1:0];

    // control state, valid bits and latched miss block; reset discards any fill in flight
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            valid_q <= '0;
            miss_q  <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            miss_q  <= miss_d;
        end
    end

    // tag and data arrays only change on an accepted memory line
    always_ff @(posedge clock) begin
        if (fill) begin
            tag_q[fill_idx]  <= miss_q[TAG_BITS+INDEX_BITS-1:INDEX_BITS];
            data_q[fill_idx] <= mem_readdata;
        end
    end

    // lookup, refill sequencing and pipeline-facing outputs
    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q;
        miss_d      = miss_q;
        Instruction = 32'h0;
        Insthit     = 1'b0;
        busywait    = 1'b0;
        mem_read    = 1'b0;
        case (state_q)
            IDLE: begin
                if (hit) begin
                    Insthit     = 1'b1;
                    Instruction = data_q[idx][{PC[3:2], 5'b0} +: 32];
                end else if (read && reset) begin
                    busywait = 1'b1;
                    miss_d   = PC[31:4];
                    state_d  = MEM_READ;
                end
            end
            MEM_READ: begin
                mem_read = 1'b1;
                busywait = 1'b1;
                if (!mem_busywait) begin
                    valid_d[fill_idx] = 1'b1;
                    state_d           = UPDATE;
                end
            end
            UPDATE: begin
                busywait = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_instruction_cache_ctrl.sv
// tb_instruction_cache_ctrl: scoreboard bench with a behavioural cache and main-memory model
module tb_instruction_cache_ctrl;
    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic [31:0]  PC = 32'h0;
    logic         read = 1'b0;
    logic [31:0]  Instruction;
    logic         Insthit;
    logic         busywait;
    logic         mem_read;
    logic [27:0]  mem_address;
    logic [127:0] mem_readdata = '0;
    logic         mem_busywait = 1'b1;

    int checks = 0;
    int failures = 0;
    int mem_wait = 0;
    int wait_cnt = 0;
    logic [31:0] exp_q[$];
    bit          ref_valid [8];
    logic [27:0] ref_blk   [8];

    instruction_cache_ctrl dut (
        .clock(clock), .reset(reset), .PC(PC), .read(read),
        .Instruction(Instruction), .Insthit(Insthit), .busywait(busywait),
        .mem_read(mem_read), .mem_address(mem_address),
        .mem_readdata(mem_readdata), .mem_busywait(mem_busywait)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] mem_word(input logic [27:0] blk, input logic [1:0] w);
        if (blk == 28'h0)
            return (w == 2'd0) ? 32'h00000193 : (w == 2'd1) ? 32'h00000113 :
                   (w == 2'd2) ? 32'h00000093 : 32'h00000013;
        return ({4'h0, blk} * 32'h9E3779B1) ^ {22'h0, w, 8'h0} ^ {30'h0, w} ^ 32'h5A5A0000;
    endfunction

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear_ref();
        for (int i = 0; i < 8; i++) ref_valid[i] = 1'b0;
    endtask

    // main memory: holds off for mem_wait cycles of mem_read, then presents the line for one edge
    initial begin
        forever begin
            @(negedge clock);
            if (mem_read && reset) begin
                if (wait_cnt > 0) begin
                    wait_cnt--;
                    mem_busywait = 1'b1;
                end else begin
                    mem_busywait = 1'b0;
                    mem_readdata = {mem_word(mem_address, 2'd3), mem_word(mem_address, 2'd2),
                                    mem_word(mem_address, 2'd1), mem_word(mem_address, 2'd0)};
                end
            end else begin
                mem_busywait = 1'b1;
                wait_cnt     = mem_wait;
            end
        end
    end

    // monitor: every delivered instruction is matched against the oldest expected word
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clock);
            if (Insthit) begin
                if (exp_q.size() == 0) chk(1'b0, "unexpected_hit", Instruction, 32'h0);
                else begin
                    e = exp_q.pop_front();
                    chk(Instruction == e, "instruction", Instruction, e);
                end
            end else chk(Instruction == 32'h0, "instr_zero_when_no_hit", Instruction, 32'h0);
        end
    end

    task automatic fetch(input logic [31:0] pc, input int wt, input bit do_pert, input logic [31:0] pert);
        logic [27:0] blk;
        logic [2:0]  idx;
        bit          exp_hit;
        bit          done;
        bit          perturbed;
        int          stall;
        blk       = pc[31:4];
        idx       = pc[6:4];
        exp_hit   = ref_valid[idx] && (ref_blk[idx] == blk);
        done      = 1'b0;
        perturbed = 1'b0;
        stall     = 0;
        @(posedge clock);
        #1;
        mem_wait = wt;
        PC       = pc;
        read     = 1'b1;
        exp_q.push_back(mem_word(blk, pc[3:2]));
        for (int c = 0; c < 60 && !done; c++) begin
            @(negedge clock);
            if (Insthit) begin
                done = 1'b1;
                chk(busywait == 1'b0, "busywait_on_hit", {31'h0, busywait}, 32'h0);
                chk(stall == (exp_hit ? 0 : wt + 3), "stall_cycles", stall, exp_hit ? 0 : wt + 3);
            end else begin
                if (c == 0) chk(busywait && !exp_hit, "miss_busywait", {31'h0, busywait}, {31'h0, !exp_hit});
                if (mem_read) begin
                    chk(mem_address == blk, "mem_address", {4'h0, mem_address}, {4'h0, blk});
                    if (do_pert && !perturbed) begin
                        PC        = pert;
                        perturbed = 1'b1;
                    end
                end else if (c > 0 && busywait) PC = pc;
                stall++;
            end
        end
        if (!done) begin
            chk(1'b0, "fetch_timeout", pc, 32'h0);
            exp_q.delete();
        end
        if (!exp_hit) begin
            ref_valid[idx] = 1'b1;
            ref_blk[idx]   = blk;
        end
    endtask

    task automatic idle_cycles(input int n);
        @(posedge clock);
        #1;
        read = 1'b0;
        for (int i = 0; i < n; i++) begin
            PC = $urandom;
            @(negedge clock);
            chk(!busywait && !Insthit && !mem_read, "idle_quiet", {29'h0, busywait, Insthit, mem_read}, 32'h0);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] pc;
        clear_ref();
        repeat (3) @(negedge clock);
        chk(!busywait && !Insthit && !mem_read && Instruction == 0, "reset_outputs",
            {28'h0, busywait, Insthit, mem_read, |Instruction}, 32'h0);
        reset = 1'b1;
        idle_cycles(2);
        fetch(32'h0, 5, 1'b0, 32'h0);
        fetch(32'h4, 0, 1'b0, 32'h0);
        fetch(32'h8, 0, 1'b0, 32'h0);
        fetch(32'hC, 0, 1'b0, 32'h0);
        fetch(32'h80, 2, 1'b0, 32'h0);
        fetch(32'h0, 1, 1'b0, 32'h0);
        idle_cycles(10);
        fetch(32'h40, 0, 1'b0, 32'h0);
        fetch(32'h80, 3, 1'b0, 32'h0);
        fetch(32'h0, 4, 1'b1, 32'h40);
        fetch(32'h44, 0, 1'b0, 32'h0);
        fetch(32'h4, 0, 1'b0, 32'h0);
        @(posedge clock);
        #1;
        mem_wait = 20;
        PC       = 32'h300;
        read     = 1'b1;
        repeat (3) @(negedge clock);
        chk(mem_read == 1'b1, "mid_fill_mem_read", {31'h0, mem_read}, 32'h1);
        reset = 1'b0;
        #1;
        chk(!mem_read && !busywait && !Insthit && Instruction == 0, "reset_mid_fill",
            {28'h0, busywait, Insthit, mem_read, |Instruction}, 32'h0);
        clear_ref();
        read = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        fetch(32'h0, 2, 1'b0, 32'h0);
        for (int i = 0; i < 250; i++) begin
            pc = ({$urandom_range(0, 1), 31'h0}) | ($urandom_range(0, 3) << 7) |
                 ($urandom_range(0, 7) << 4) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
            fetch(pc, $urandom_range(0, 4), $urandom_range(0, 3) == 0, $urandom);
            if ($urandom_range(0, 7) == 0) idle_cycles($urandom_range(1, 3));
        end
        idle_cycles(2);
        chk(exp_q.size() == 0, "scoreboard_drained", exp_q.size(), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
